// File: rtl/gshare_pred.sv
// gshare_pred: global-history branch direction predictor.
// A table of saturating counters is indexed by PC XOR a speculative global
// history register. Lookups are issued at fetch and produce a registered
// prediction one cycle later; training and history repair arrive from
// execute. Two saturating 32-bit counters track resolved branches and
// mispredicts.
module gshare_pred #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 8,
    parameter int CNT_W  = 2,
    parameter int HIST_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    // lookup request from fetch
    input  logic              pred_valid,
    input  logic [PC_W-1:0]   pred_pc,
    // registered prediction
    output logic              pred_out_valid,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_idx,
    output logic [HIST_W-1:0] pred_hist,
    // resolution from execute
    input  logic              upd_valid,
    input  logic              upd_taken,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_mispred,
    // performance counters
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispreds
);

    localparam int DEPTH = 2 ** IDX_W;

    // Counters start weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MIN  = '0;
    localparam logic [31:0]      STAT_MAX = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Move a direction counter one step toward the resolved outcome,
    // clamping at both ends so it can never wrap.
    function automatic logic [CNT_W-1:0] cnt_train(
        input logic [CNT_W-1:0] cnt,
        input logic             taken
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != CNT_MAX) res = cnt + CNT_W'(1);
        end else begin
            if (cnt != CNT_MIN) res = cnt - CNT_W'(1);
        end
        return res;
    endfunction

    // Shift a new outcome into the LSB of a history value, dropping the MSB.
    // Written via a widened temporary so HIST_W=1 needs no special case.
    function automatic logic [HIST_W-1:0] hist_shift(
        input logic [HIST_W-1:0] hist,
        input logic              dir
    );
        logic [HIST_W:0] ext;
        ext = {hist, dir};
        return ext[HIST_W-1:0];
    endfunction

    // Increment a 32-bit statistic, sticking at all-ones.
    function automatic logic [31:0] stat_inc(input logic [31:0] val);
        logic [31:0] res;
        res = val;
        if (val != STAT_MAX) res = val + 32'd1;
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  tbl_q [DEPTH];
    logic [HIST_W-1:0] ghr_q;
    logic [HIST_W-1:0] ghr_d;

    logic              out_vld_q;
    logic              out_taken_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic [HIST_W-1:0] out_hist_q;
    logic              out_vld_d;
    logic              out_taken_d;
    logic [IDX_W-1:0]  out_idx_d;
    logic [HIST_W-1:0] out_hist_d;

    logic [31:0]       branches_q;
    logic [31:0]       mispreds_q;
    logic [31:0]       branches_d;
    logic [31:0]       mispreds_d;

    logic [CNT_W-1:0]  wr_cnt_d;

    // ------------------------------------------------------------------
    // Lookup path (combinational, reads the table before this edge's write)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  lk_idx;
    logic [CNT_W-1:0]  lk_cnt;
    logic              lk_taken;
    logic              repair;

    // Word-aligned PC bits hashed with the LSB-aligned history.
    assign lk_idx   = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign lk_cnt   = tbl_q[lk_idx];
    assign lk_taken = lk_cnt[CNT_W-1];

    // A mispredict repair only counts when the resolution itself is valid.
    assign repair   = upd_valid && upd_mispred;

    // PC bits outside the index field, and the history MSB that is shifted
    // out on repair, have no effect on the predictor.
    logic unused_bits;
    assign unused_bits = ^{pred_pc[1:0], pred_pc[PC_W-1:IDX_W+2], upd_hist[HIST_W-1]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Prediction outputs: capture on a lookup, otherwise hold with valid low.
    always_comb begin
        out_vld_d   = 1'b0;
        out_taken_d = out_taken_q;
        out_idx_d   = out_idx_q;
        out_hist_d  = out_hist_q;
        if (pred_valid) begin
            out_vld_d   = 1'b1;
            out_taken_d = lk_taken;
            out_idx_d   = lk_idx;
            out_hist_d  = ghr_q;
        end
    end

    // History: a repair from execute overrides the speculative lookup shift.
    always_comb begin
        ghr_d = ghr_q;
        if (repair) begin
            ghr_d = hist_shift(upd_hist, upd_taken);
        end else if (pred_valid) begin
            ghr_d = hist_shift(ghr_q, lk_taken);
        end
    end

    // Training value for the resolved entry and the statistics counters.
    always_comb begin
        wr_cnt_d   = cnt_train(tbl_q[upd_idx], upd_taken);
        branches_d = branches_q;
        mispreds_d = mispreds_q;
        if (upd_valid) begin
            branches_d = stat_inc(branches_q);
            if (upd_mispred) begin
                mispreds_d = stat_inc(mispreds_q);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Counter table: cleared to weakly not-taken, written on each resolution.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= CNT_INIT;
            end
        end else if (upd_valid) begin
            tbl_q[upd_idx] <= wr_cnt_d;
        end
    end

    // Speculative global history register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // Registered prediction presented to fetch one cycle after the request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vld_q   <= 1'b0;
            out_taken_q <= 1'b0;
            out_idx_q   <= '0;
            out_hist_q  <= '0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_taken_q <= out_taken_d;
            out_idx_q   <= out_idx_d;
            out_hist_q  <= out_hist_d;
        end
    end

    // Performance counters, updated on the same edge as the training write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            branches_q <= '0;
            mispreds_q <= '0;
        end else begin
            branches_q <= branches_d;
            mispreds_q <= mispreds_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pred_out_valid = out_vld_q;
    assign pred_taken     = out_taken_q;
    assign pred_idx       = out_idx_q;
    assign pred_hist      = out_hist_q;
    assign stat_branches  = branches_q;
    assign stat_mispreds  = mispreds_q;

endmodule

// File: tb/tb_gshare_pred.sv
// Testbench for gshare_pred: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the predictor.
module tb_gshare_pred;

    localparam int PC_W   = 32;
    localparam int IDX_W  = 8;
    localparam int CNT_W  = 2;
    localparam int HIST_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              pred_valid = 1'b0;
    logic [PC_W-1:0]   pred_pc = '0;
    logic              pred_out_valid;
    logic              pred_taken;
    logic [IDX_W-1:0]  pred_idx;
    logic [HIST_W-1:0] pred_hist;
    logic              upd_valid = 1'b0;
    logic              upd_taken = 1'b0;
    logic [IDX_W-1:0]  upd_idx = '0;
    logic [HIST_W-1:0] upd_hist = '0;
    logic              upd_mispred = 1'b0;
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispreds;

    gshare_pred #(
        .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .HIST_W(HIST_W)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .pred_hist      (pred_hist),
        .upd_valid      (upd_valid),
        .upd_taken      (upd_taken),
        .upd_idx        (upd_idx),
        .upd_hist       (upd_hist),
        .upd_mispred    (upd_mispred),
        .stat_branches  (stat_branches),
        .stat_mispreds  (stat_mispreds)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: counters as plain integers 0..3, history as an int.
    int     m_tbl [DEPTH];
    int     m_ghr;
    bit     e_ov, e_tk;
    int     e_idx, e_hist;
    longint e_br, e_mp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
        m_ghr = 0;
        e_ov = 0; e_tk = 0; e_idx = 0; e_hist = 0;
        e_br = 0; e_mp = 0;
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        int idx;
        int g_next;
        int ui;
        bit tk;
        g_next = m_ghr;
        if (pred_valid) begin
            idx    = int'((pred_pc >> 2) & 32'hFF) ^ m_ghr;
            tk     = (m_tbl[idx] >= 2);
            e_ov   = 1; e_tk = tk; e_idx = idx; e_hist = m_ghr;
            g_next = ((m_ghr << 1) | int'(tk)) & 255;
        end else begin
            e_ov = 0;
        end
        if (upd_valid) begin
            ui = int'(upd_idx);
            if (upd_taken) m_tbl[ui] = (m_tbl[ui] < 3) ? m_tbl[ui] + 1 : 3;
            else           m_tbl[ui] = (m_tbl[ui] > 0) ? m_tbl[ui] - 1 : 0;
            if (e_br < 64'hFFFF_FFFF) e_br++;
            if (upd_mispred) begin
                if (e_mp < 64'hFFFF_FFFF) e_mp++;
                g_next = ((int'(upd_hist) << 1) | int'(upd_taken)) & 255;
            end
        end
        m_ghr = g_next;
    endtask

    task automatic compare_all();
        check("out_valid", pred_out_valid, e_ov);
        check("taken",     pred_taken,     e_tk);
        check("idx",       pred_idx,       e_idx);
        check("hist",      pred_hist,      e_hist);
        check("branches",  stat_branches,  e_br);
        check("mispreds",  stat_mispreds,  e_mp);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit pv, input logic [31:0] pc, input bit uv, input bit ut,
                         input int ui, input int uh, input bit mp);
        pred_valid  = pv;
        pred_pc     = pc;
        upd_valid   = uv;
        upd_taken   = ut;
        upd_idx     = IDX_W'(ui);
        upd_hist    = HIST_W'(uh);
        upd_mispred = mp;
    endtask

    task automatic drive_random();
        drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 255),
              $urandom_range(0, 3) == 0);
    endtask

    // Asynchronous reset asserted mid-cycle with traffic still being driven.
    task automatic async_reset();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check("rst_valid",    pred_out_valid, 0);
        check("rst_taken",    pred_taken,     0);
        check("rst_idx",      pred_idx,       0);
        check("rst_hist",     pred_hist,      0);
        check("rst_branches", stat_branches,  0);
        check("rst_mispreds", stat_mispreds,  0);
        drive_random();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
    endtask

    function automatic logic [31:0] pc_for(input int idx);
        return 32'((idx ^ m_ghr) & 255) << 2;
    endfunction

    logic [31:0] mp_before;

    initial begin
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rstn = 1'b1;

        // some traffic, then reset in the middle of it
        for (int i = 0; i < 20; i++) begin
            drive_random();
            step();
        end
        async_reset();

        // first lookup after reset
        drive(1, 32'h14, 0, 0, 0, 0, 0);
        step();
        check("post_rst_idx",   pred_idx,   8'h05);
        check("post_rst_taken", pred_taken, 1'b0);
        check("post_rst_hist",  pred_hist,  8'h00);

        // saturate up at index 5
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 1, 5, 0, 0);
            step();
        end
        check("sat_up_branches", stat_branches, 4);

        // three back-to-back lookups of the same PC walk the history
        drive(1, 32'h14, 0, 0, 0, 0, 0);
        step();
        check("hs1_idx",   pred_idx,   8'h05);
        check("hs1_hist",  pred_hist,  8'h00);
        check("hs1_taken", pred_taken, 1'b1);
        step();
        check("hs2_idx",   pred_idx,   8'h04);
        check("hs2_hist",  pred_hist,  8'h01);
        step();
        check("hs3_hist",  pred_hist,  8'h02);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();

        // saturate down at index 5, no wrap
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 5, 0, 0);
            step();
        end
        drive(1, pc_for(5), 0, 0, 0, 0, 0);
        step();
        check("sat_dn_idx",   pred_idx,   8'h05);
        check("sat_dn_taken", pred_taken, 1'b0);

        // mispredict repair with a same-cycle lookup
        mp_before = stat_mispreds;
        drive(1, 32'h0000_0340, 1, 1, 8'h30, 8'h5A, 1);
        step();
        check("repair_mispreds", stat_mispreds, mp_before + 32'd1);
        drive(1, 32'h0000_0100, 0, 0, 0, 0, 0);
        step();
        check("repair_hist", pred_hist, 8'hB5);

        // read-before-write collision at an entry holding 10
        drive(0, 0, 1, 1, 9, 0, 0);
        step();
        drive(1, pc_for(9), 1, 0, 9, 0, 0);
        step();
        check("coll_idx",   pred_idx,   8'h09);
        check("coll_taken", pred_taken, 1'b1);
        drive(1, pc_for(9), 0, 0, 0, 0, 0);
        step();
        check("coll_after_idx",   pred_idx,   8'h09);
        check("coll_after_taken", pred_taken, 1'b0);

        // randomized traffic with another reset partway through
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            drive_random();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Overall time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gshare_pred.md
# gshare_pred

Parametrised global-history branch direction predictor for the fetch stage, successor to the single-counter predictor. A table of 2^IDX_W saturating CNT_W-bit counters is indexed by PC XOR a speculative global history register (GHR). Lookup is issued at fetch, and training happens at branch resolution in execute. On a mispredict the GHR is repaired from a snapshot carried down the pipeline. Two 32-bit performance counters track resolved branches and mispredicts.

## Interface
- PC_W, 32: PC width.
- IDX_W, 8: table index width; table depth is 2^IDX_W.
- CNT_W, 2: counter width, 2..4.
- HIST_W, 8: GHR width, 1..IDX_W.

- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- pred_valid  in  1  lookup request this cycle.
- pred_pc  in  PC_W  PC of the fetched instruction; bits [1:0] are ignored.
- pred_out_valid  out  1  prediction valid; asserted one cycle after pred_valid.
- pred_taken  out  1  predicted direction (counter MSB).
- pred_idx  out  IDX_W  table index used; carried with the branch.
- pred_hist  out  HIST_W  GHR value before this lookup's speculative shift; carried with the branch.
- upd_valid  in  1  a branch resolved this cycle.
- upd_taken  in  1  actual direction.
- upd_idx  in  IDX_W  pred_idx returned from the pipeline.
- upd_hist  in  HIST_W  pred_hist returned from the pipeline.
- upd_mispred  in  1  predicted direction was wrong; qualified by upd_valid.
- stat_branches  out  32  count of resolved branches.
- stat_mispreds  out  32  count of mispredicts.

## Operation
- Index: idx = pred_pc[IDX_W+1:2] XOR zero_extend(GHR), with the GHR aligned to the LSB.
- Counter init value is 2^(CNT_W-1)-1 (weakly not-taken). Taken when the MSB is 1.
- Lookup, cycle N with pred_valid=1:
  - Read table[idx] in cycle N.
  - At the edge: register pred_taken, pred_idx = idx, pred_hist = GHR (pre-shift), and pred_out_valid=1.
  - Also at the edge: GHR <= {GHR[HIST_W-2:0], predicted}.
  - With pred_valid=0: pred_out_valid=0 next cycle. The other outputs hold their last values.
- Training, upd_valid=1:
  - Taken: table[upd_idx] increments, saturating at 2^CNT_W-1.
  - Not taken: table[upd_idx] decrements, saturating at 0.
  - No wrap-around under any input sequence.
- Repair, upd_valid=1 and upd_mispred=1: GHR <= {upd_hist[HIST_W-2:0], upd_taken}.
  - This overrides any same-cycle lookup shift.
  - The same-cycle lookup still produces its prediction, indexed with the pre-repair GHR.
  - Flushing that lookup is the front end's job.
- upd_mispred is ignored when upd_valid=0.
- Same-cycle lookup and update to the same index: the lookup sees the old counter value (read-before-write). The write still lands.
- Statistics:
  - stat_branches increments on each upd_valid.
  - stat_mispreds increments on each upd_valid and upd_mispred.
  - Both saturate at 0xFFFF_FFFF.
- Reset (async, any time, including mid-training):
  - All counters are set to init; GHR=0.
  - pred_out_valid=0, pred_taken=0, pred_idx=0, pred_hist=0.
  - Stats are set to 0.
  - Requests held during reset are ignored.

## Timing
- Prediction latency is 1 cycle: request at edge N, result valid after edge N+1.
- Back-to-back lookups every cycle are supported. Lookup N+1 indexes with the GHR already shifted by lookup N.
- A table update at edge N is visible to lookups issued in cycle N+1 or later.
- A GHR repair at edge N is used by the lookup in cycle N+1.
- Stats update at the same edge as the training write.
- There is no backpressure: inputs are sampled every cycle, and outputs carry no ready signal.

## Test plan
- Reset: assert rstn=0 mid-stream, then release.
  - All outputs are 0; the GHR is 0.
  - A lookup with pred_pc=0x14 returns pred_idx=0x05, pred_taken=0, pred_hist=0x00.
- Saturate up: 4 taken updates on upd_idx=0x05, non-mispredict.
  - Counter goes 01→10→11→11.
  - A lookup hitting 0x05 returns pred_taken=1.
  - stat_branches=4.
- Saturate down, from 11: 5 not-taken updates.
  - Counter goes 11→10→01→00→00.
  - pred_taken=0; no wrap to 11.
- History shift: three consecutive lookups pred_pc=0x14, 0x14, 0x14 after training 0x05 to 11.
  - Lookup 1: pred_idx=0x05, pred_hist=0x00.
  - Lookup 2: pred_idx=0x04, pred_hist=0x01.
  - Lookup 3: pred_hist=0x02 or 0x03, depending on the counter state at index 0x04.
- Mispredict repair plus same-cycle lookup:
  - Stimulus: upd_valid=1, upd_mispred=1, upd_hist=0x5A, upd_taken=1, together with pred_valid=1.
  - Next-cycle lookup shows pred_hist=0xB5.
  - stat_mispreds increments by 1.
- Read/write collision: lookup and not-taken update to the same index whose counter is 10, in the same cycle.
  - The prediction returns pred_taken=1.
  - A lookup one cycle later returns pred_taken=0.
